// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART frame transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_IDLE,
        ST_STROBE,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } tx_state_t;

    localparam logic [7:0] DEF_TERM_BYTE = 8'h0A;

    // Wide enough for the longest frame: 8 payload + checksum + terminator.
    localparam int IDX_W = 4;

    function automatic int frame_len(input int n_bytes, input int checksum_en);
        return n_bytes + checksum_en + 1;
    endfunction

endpackage

// File: rtl/uart_frame_byte_sel.sv
// Picks the next frame byte: payload top byte, checksum, or terminator, by index.
// Latency: combinational.
// Backpressure: none; the caller decides when the selection is sampled.
module uart_frame_byte_sel
    import uart_pkg::*;
#(
    parameter int         N_BYTES     = 3,
    parameter int         CHECKSUM_EN = 0,
    parameter logic [7:0] TERM_BYTE   = DEF_TERM_BYTE
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       top_byte,
    input  logic [7:0]       csum,
    output logic [7:0]       sel_byte
);

    always_comb begin
        sel_byte = TERM_BYTE;
        if (idx < IDX_W'(N_BYTES)) begin
            sel_byte = top_byte;
        end else if ((CHECKSUM_EN != 0) && (idx == IDX_W'(N_BYTES))) begin
            sel_byte = csum;
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Serialises one payload word into payload bytes (MSB first), optional XOR checksum, terminator.
// Latency: accept edge to first tx_en is 3 cycles when the byte core is idle.
// Backpressure: frame_ready low for the whole frame; each byte waits for tx_busy to clear.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int         N_BYTES     = 3,
    parameter logic [7:0] TERM_BYTE   = DEF_TERM_BYTE,
    parameter int         CHECKSUM_EN = 0,
    parameter int         ACK_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8*N_BYTES-1:0]   frame_data,
    input  logic                   frame_valid,
    output logic                   frame_ready,
    output logic                   frame_busy,
    output logic                   frame_done,
    output logic                   ack_err,
    output logic                   tx_en,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy
);

    localparam int               PW       = 8 * N_BYTES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(frame_len(N_BYTES, CHECKSUM_EN) - 1);
    localparam int               TO_W     = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(ACK_TIMEOUT);

    tx_state_t        state;
    logic [PW-1:0]    shreg;
    logic [IDX_W-1:0] idx;
    logic [7:0]       csum;
    logic [TO_W-1:0]  to_cnt;
    logic [7:0]       sel_byte;

    uart_frame_byte_sel #(
        .N_BYTES     (N_BYTES),
        .CHECKSUM_EN (CHECKSUM_EN),
        .TERM_BYTE   (TERM_BYTE)
    ) u_byte_sel (
        .idx      (idx),
        .top_byte (shreg[PW-1 -: 8]),
        .csum     (csum),
        .sel_byte (sel_byte)
    );

    assign frame_busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            idx         <= '0;
            csum        <= '0;
            to_cnt      <= '0;
            frame_ready <= 1'b1;
            frame_done  <= 1'b0;
            ack_err     <= 1'b0;
            tx_en       <= 1'b0;
            tx_data     <= 8'h00;
        end else begin
            tx_en      <= 1'b0;
            frame_done <= 1'b0;
            ack_err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_valid && frame_ready) begin
                        shreg       <= frame_data;
                        csum        <= '0;
                        idx         <= '0;
                        frame_ready <= 1'b0;
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // tx_data is held from here until the core has finished this byte.
                    tx_data <= sel_byte;
                    if (idx < IDX_W'(N_BYTES)) begin
                        csum <= csum ^ shreg[PW-1 -: 8];
                    end
                    state <= ST_WAIT_IDLE;
                end
                ST_WAIT_IDLE: begin
                    if (!tx_busy) begin
                        state <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    tx_en  <= 1'b1;
                    to_cnt <= '0;
                    state  <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (to_cnt == TO_MAX) begin
                        // Core never picked up the byte: drop the rest of the frame.
                        ack_err     <= 1'b1;
                        frame_ready <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (idx == LAST_IDX) begin
                            frame_done  <= 1'b1;
                            frame_ready <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            shreg <= shreg << 8;
                            state <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    frame_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: plain and checksum instances share one byte-core model.
// Expected bytes are queued at stimulus time and compared once the frame has been sent.
module tb_uart_frame_tx;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] frame_data0, frame_data1;
    logic        frame_valid0, frame_valid1;
    logic        frame_ready0, frame_ready1;
    logic        frame_busy0, frame_busy1;
    logic        frame_done0, frame_done1;
    logic        ack_err0, ack_err1;
    logic        tx_en0, tx_en1;
    logic [7:0]  tx_data0, tx_data1;
    logic        tx_busy;
    logic        core_busy = 1'b0;
    logic        busy_force;
    logic        core_mute;

    always #5 clk = ~clk;

    assign tx_busy = core_busy | busy_force;

    uart_frame_tx #(.N_BYTES(3), .TERM_BYTE(8'h0A), .CHECKSUM_EN(0), .ACK_TIMEOUT(TMO)) dut0 (
        .clk(clk), .reset(reset), .frame_data(frame_data0), .frame_valid(frame_valid0),
        .frame_ready(frame_ready0), .frame_busy(frame_busy0), .frame_done(frame_done0),
        .ack_err(ack_err0), .tx_en(tx_en0), .tx_data(tx_data0), .tx_busy(tx_busy)
    );

    uart_frame_tx #(.N_BYTES(3), .TERM_BYTE(8'h0A), .CHECKSUM_EN(1), .ACK_TIMEOUT(TMO)) dut1 (
        .clk(clk), .reset(reset), .frame_data(frame_data1), .frame_valid(frame_valid1),
        .frame_ready(frame_ready1), .frame_busy(frame_busy1), .frame_done(frame_done1),
        .ack_err(ack_err1), .tx_en(tx_en1), .tx_data(tx_data1), .tx_busy(tx_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Byte-core model and monitor: busy rises 2 cycles after a strobe and stays up 20 cycles.
    logic [7:0] got_arr [256];
    int         en_cyc_arr [256];
    int         got_n = 0, done_n = 0, err_n = 0;
    int         done_cyc = 0, err_cyc = 0, fall_cyc = 0;
    int         dly = 0, bcnt = 0;

    always @(negedge clk) begin
        if (tx_en0 || tx_en1) begin
            got_arr[8'(got_n)]    = tx_en0 ? tx_data0 : tx_data1;
            en_cyc_arr[8'(got_n)] = cyc;
            got_n = got_n + 1;
            if (!core_mute) dly = 2;
        end else if (dly > 0) begin
            dly = dly - 1;
            if (dly == 0) begin
                core_busy = 1'b1;
                bcnt = 20;
            end
        end else if (core_busy) begin
            bcnt = bcnt - 1;
            if (bcnt == 0) begin
                core_busy = 1'b0;
                fall_cyc = cyc;
            end
        end
        if (frame_done0 || frame_done1) begin
            done_n = done_n + 1;
            done_cyc = cyc;
        end
        if (ack_err0 || ack_err1) begin
            err_n = err_n + 1;
            err_cyc = cyc;
        end
    end

    int         passed = 0, total = 0;
    logic [7:0] exp_q [$];
    int         acc_cyc;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send0(input logic [23:0] d);
        for (int i = 0; i < 3; i++) exp_q.push_back(d[8*(2-i) +: 8]);
        exp_q.push_back(8'h0A);
        frame_data0  = d;
        frame_valid0 = 1'b1;
        tick();
        acc_cyc      = cyc;
        frame_valid0 = 1'b0;
    endtask

    task automatic send1(input logic [23:0] d);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(d[8*(2-i) +: 8]);
            x = x ^ d[8*(2-i) +: 8];
        end
        exp_q.push_back(x);
        exp_q.push_back(8'h0A);
        frame_data1  = d;
        frame_valid1 = 1'b1;
        tick();
        frame_valid1 = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick();
            if (done_n >= target) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if (frame_ready0 === 1'b1) passed++; else $display("FAIL rst_ready got %b required 1", frame_ready0);
        total++; if (frame_busy0 === 1'b0) passed++; else $display("FAIL rst_busy got %b required 0", frame_busy0);
        total++; if (frame_done0 === 1'b0) passed++; else $display("FAIL rst_done got %b required 0", frame_done0);
        total++; if (ack_err0 === 1'b0) passed++; else $display("FAIL rst_ack_err got %b required 0", ack_err0);
        total++; if (tx_en0 === 1'b0) passed++; else $display("FAIL rst_tx_en got %b required 0", tx_en0);
        total++; if (tx_data0 === 8'h00) passed++; else $display("FAIL rst_tx_data got %h required 00", tx_data0);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int gb, db, k;
        logic [7:0] e, g;
        bit ok;
        gb = got_n; db = done_n;
        send0(24'h14_00_00);
        wait_done(db + 1, 400, ok);
        total++; if (ok) passed++; else $display("FAIL basic_done_timeout done_n %0d required %0d", done_n, db + 1);
        total++; if (en_cyc_arr[8'(gb)] - acc_cyc == 3) passed++;
        else $display("FAIL basic_latency got %0d required 3", en_cyc_arr[8'(gb)] - acc_cyc);
        total++; if (done_cyc - fall_cyc == 1) passed++;
        else $display("FAIL basic_done_timing got %0d required 1", done_cyc - fall_cyc);
        tick();
        total++; if (frame_ready0 === 1'b1 && frame_done0 === 1'b0) passed++;
        else $display("FAIL basic_after_done ready %b done %b required 1 0", frame_ready0, frame_done0);
        repeat (5) tick();
        total++; if (got_n - gb == 4) passed++; else $display("FAIL basic_strobes got %0d required 4", got_n - gb);
        total++; if (done_n - db == 1) passed++; else $display("FAIL basic_done_pulses got %0d required 1", done_n - db);
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (gb + k < got_n) ? got_arr[8'(gb + k)] : 8'hxx;
            total++; if (g === e) passed++; else $display("FAIL basic_byte%0d got %h required %h", k, g, e);
            k++;
        end
    endtask

    task automatic test_checksum();
        int gb, db, k;
        logic [7:0] e, g;
        bit ok;
        gb = got_n; db = done_n;
        send1(24'hA5_3C_0F);
        wait_done(db + 1, 400, ok);
        total++; if (ok) passed++; else $display("FAIL csum_done_timeout done_n %0d required %0d", done_n, db + 1);
        repeat (3) tick();
        total++; if (got_n - gb == 5) passed++; else $display("FAIL csum_strobes got %0d required 5", got_n - gb);
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (gb + k < got_n) ? got_arr[8'(gb + k)] : 8'hxx;
            total++; if (g === e) passed++; else $display("FAIL csum_byte%0d got %h required %h", k, g, e);
            k++;
        end
    endtask

    task automatic test_back_to_back();
        int gb, db, d, a2, k;
        logic [7:0] e, g;
        bit ok, ok1, ok2;
        gb = got_n; db = done_n; a2 = 0;
        for (int i = 0; i < 3; i++) exp_q.push_back(8'(i + 1));
        exp_q.push_back(8'h0A);
        for (int i = 0; i < 3; i++) exp_q.push_back(8'(i + 4));
        exp_q.push_back(8'h0A);
        frame_data0  = 24'h010203;
        frame_valid0 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            if (frame_ready0 === 1'b0) ok = 1'b1;
        end
        total++; if (ok) passed++; else $display("FAIL b2b_accept1 ready %b required 0", frame_ready0);
        frame_data0 = 24'h040506;
        wait_done(db + 1, 400, ok1);
        d = done_cyc;
        ok2 = 1'b0;
        for (int i = 0; i < 5 && !ok2; i++) begin
            tick();
            if (frame_ready0 === 1'b0) begin
                ok2 = 1'b1;
                a2 = cyc;
            end
        end
        frame_valid0 = 1'b0;
        total++; if (ok1 && ok2 && a2 - d == 1) passed++;
        else $display("FAIL b2b_gap got %0d required 1 (done_seen %b accept_seen %b)", a2 - d, ok1, ok2);
        wait_done(db + 2, 400, ok);
        total++; if (ok) passed++; else $display("FAIL b2b_done_timeout done_n %0d required %0d", done_n, db + 2);
        repeat (3) tick();
        total++; if (got_n - gb == 8) passed++; else $display("FAIL b2b_strobes got %0d required 8", got_n - gb);
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (gb + k < got_n) ? got_arr[8'(gb + k)] : 8'hxx;
            total++; if (g === e) passed++; else $display("FAIL b2b_byte%0d got %h required %h", k, g, e);
            k++;
        end
    endtask

    task automatic test_ack_timeout();
        int gb, db, eb;
        bit ok;
        gb = got_n; db = done_n; eb = err_n;
        core_mute = 1'b1;
        send0(24'h55_66_77);
        exp_q.delete();
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            tick();
            if (err_n > eb) ok = 1'b1;
        end
        total++; if (ok) passed++; else $display("FAIL tmo_err_timeout err_n %0d required %0d", err_n, eb + 1);
        total++; if (err_cyc - en_cyc_arr[8'(gb)] == TMO + 1) passed++;
        else $display("FAIL tmo_delay got %0d required %0d", err_cyc - en_cyc_arr[8'(gb)], TMO + 1);
        tick();
        total++; if (frame_ready0 === 1'b1 && ack_err0 === 1'b0) passed++;
        else $display("FAIL tmo_after ready %b ack_err %b required 1 0", frame_ready0, ack_err0);
        repeat (5) tick();
        total++; if (done_n == db && got_n - gb == 1) passed++;
        else $display("FAIL tmo_no_done done %0d strobes %0d required 0 1", done_n - db, got_n - gb);
        core_mute = 1'b0;
    endtask

    task automatic test_busy_hold();
        int gb, db, f, k;
        logic [7:0] e, g;
        bit ok;
        gb = got_n; db = done_n;
        busy_force = 1'b1;
        send0(24'hC0_FF_EE);
        repeat (50) tick();
        total++; if (got_n == gb) passed++; else $display("FAIL hold_no_strobe got %0d required 0", got_n - gb);
        busy_force = 1'b0;
        f = cyc;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            if (got_n > gb) ok = 1'b1;
        end
        // Edge f+1 is the first to see busy low; the strobe should be visible one cycle later.
        total++; if (ok && en_cyc_arr[8'(gb)] - (f + 1) == 1) passed++;
        else $display("FAIL hold_strobe_delay got %0d required 1 (seen %b)", en_cyc_arr[8'(gb)] - (f + 1), ok);
        wait_done(db + 1, 400, ok);
        total++; if (ok) passed++; else $display("FAIL hold_done_timeout done_n %0d required %0d", done_n, db + 1);
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (gb + k < got_n) ? got_arr[8'(gb + k)] : 8'hxx;
            total++; if (g === e) passed++; else $display("FAIL hold_byte%0d got %h required %h", k, g, e);
            k++;
        end
    endtask

    task automatic test_mid_reset();
        int gb, db, eb, k;
        logic [7:0] e, g;
        bit ok;
        gb = got_n; db = done_n; eb = err_n;
        send0(24'hAA_BB_CC);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (got_n >= gb + 2) ok = 1'b1;
        end
        total++; if (ok) passed++; else $display("FAIL mid_second_byte strobes %0d required 2", got_n - gb);
        reset = 1'b1;
        tick();
        total++; if (frame_ready0 === 1'b1 && frame_busy0 === 1'b0) passed++;
        else $display("FAIL mid_rst_state ready %b busy %b required 1 0", frame_ready0, frame_busy0);
        total++; if (tx_en0 === 1'b0 && tx_data0 === 8'h00) passed++;
        else $display("FAIL mid_rst_tx tx_en %b tx_data %h required 0 00", tx_en0, tx_data0);
        reset = 1'b0;
        exp_q.delete();
        repeat (30) tick();
        total++; if (done_n == db && err_n == eb) passed++;
        else $display("FAIL mid_rst_pulses done %0d err %0d required 0 0", done_n - db, err_n - eb);
        gb = got_n;
        send0(24'h11_22_33);
        wait_done(db + 1, 400, ok);
        total++; if (ok) passed++; else $display("FAIL mid_done_timeout done_n %0d required %0d", done_n, db + 1);
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (gb + k < got_n) ? got_arr[8'(gb + k)] : 8'hxx;
            total++; if (g === e) passed++; else $display("FAIL mid_byte%0d got %h required %h", k, g, e);
            k++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish, %0d/%0d checks passed so far", passed, total);
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        frame_valid0 = 1'b0;
        frame_valid1 = 1'b0;
        frame_data0  = '0;
        frame_data1  = '0;
        busy_force   = 1'b0;
        core_mute    = 1'b0;
        test_reset();
        test_basic();
        test_checksum();
        test_back_to_back();
        test_ack_timeout();
        test_busy_hold();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
